mem_port_arbiter: RTL

//  Parametrised successor to the single-channel core-to-RAM glue in the minimal SoC. Arbitrates NUM_CH

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_port_arbiter_rr_arbiter.sv | 55 +++++
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and helpers for the multi-channel byte-RAM port arbiter.
// FSM encodings are plain localparams so older tools and checkers can bind to them directly.
package mem_port_arbiter_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_XFER  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef logic [1:0] len_t;
   typedef logic [7:0] byte_t;

   function automatic byte_t byte_sel(input logic [31:0] word, input len_t k);
      return word[{k, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Request arbiter: round-robin after the last granted index, or fixed lowest-index priority.
// Owns the last-grant pointer, which moves only when a grant is actually issued.
module mem_port_arbiter_rr_arbiter #(
   parameter int NUM_CH  = 2,
   parameter int RR_MODE = 1,
   parameter int IDX_W   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] req,
   input  logic              grant_en,
   output logic [NUM_CH-1:0] grant,
   output logic [IDX_W-1:0]  grant_idx,
   output logic              grant_any
);

   localparam int IW1 = IDX_W + 1;

   logic [IDX_W-1:0] ptr_q;
   logic [IW1-1:0]   start;
   logic [IW1-1:0]   cand;
   logic             found;

   always_comb begin
      start     = '0;
      cand      = '0;
      found     = 1'b0;
      grant_idx = '0;
      if (RR_MODE != 0) begin
         start = {1'b0, ptr_q} + IW1'(1);
         if (start >= IW1'(NUM_CH)) start = '0;
      end
      // Scan from the starting index, wrapping, and keep the first requester seen.
      for (int i = 0; i < NUM_CH; i++) begin
         cand = start + IW1'(i);
         if (cand >= IW1'(NUM_CH)) cand = cand - IW1'(NUM_CH);
         if (!found && req[cand[IDX_W-1:0]]) begin
            found     = 1'b1;
            grant_idx = cand[IDX_W-1:0];
         end
      end
      grant_any = found && grant_en;
      grant     = '0;
      if (grant_any) grant[grant_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= IDX_W'(NUM_CH - 1);
      end else if (grant_any) begin
         ptr_q <= grant_idx;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises 1..4-byte channel accesses onto a byte-wide synchronous RAM and reassembles read words.
// Handshake: a channel holds ch_req_i with stable fields until its one-cycle ch_done_o pulse; fields are latched at grant.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int NUM_CH  = 2,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int RR_MODE = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     halt_i,
   input  logic [NUM_CH-1:0]        ch_req_i,
   input  logic [NUM_CH-1:0]        ch_wr_i,
   input  logic [NUM_CH*2-1:0]      ch_len_i,
   input  logic [NUM_CH*ADDR_W-1:0] ch_addr_i,
   input  logic [NUM_CH*DATA_W-1:0] ch_wdata_i,
   output logic [DATA_W-1:0]        ch_rdata_o,
   output logic [NUM_CH-1:0]        ch_done_o,
   output logic                     busy_o,
   output logic                     ram_en_o,
   output logic                     ram_wr_o,
   output logic [ADDR_W-1:0]        ram_addr_o,
   output logic [7:0]               ram_dout_o,
   input  logic [7:0]               ram_din_i,
   output logic [1:0]               state_dbg
);

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [1:0]        state_q, state_n;
   logic [NUM_CH-1:0] grant, gnt_q;
   logic [IDX_W-1:0]  grant_idx;
   logic              grant_any, grant_en;
   logic              wr_q, sel_wr;
   len_t              len_q, cnt_q, cnt_n, sel_len, cap_idx;
   logic [ADDR_W-1:0] addr_q, sel_addr;
   logic [DATA_W-1:0] wdata_q, sel_wdata, asm_q, asm_n;

   assign grant_en  = (state_q == ST_IDLE) && !halt_i;
   assign state_dbg = state_q;

   mem_port_arbiter_rr_arbiter #(
      .NUM_CH (NUM_CH),
      .RR_MODE(RR_MODE),
      .IDX_W  (IDX_W)
   ) u_arb (
      .clk      (clk),
      .rst      (rst),
      .req      (ch_req_i),
      .grant_en (grant_en),
      .grant    (grant),
      .grant_idx(grant_idx),
      .grant_any(grant_any)
   );

   always_comb begin
      sel_wr    = 1'b0;
      sel_len   = '0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant_idx == IDX_W'(i)) begin
            sel_wr    = ch_wr_i[i];
            sel_len   = ch_len_i[2*i +: 2];
            sel_addr  = ch_addr_i[ADDR_W*i +: ADDR_W];
            sel_wdata = ch_wdata_i[DATA_W*i +: DATA_W];
         end
      end
   end

   always_comb begin
      state_n = state_q;
      case (state_q)
         ST_IDLE:  if (grant_any) state_n = ST_XFER;
         ST_XFER:  if (cnt_q == len_q) state_n = wr_q ? ST_DONE : ST_DRAIN;
         ST_DRAIN: state_n = ST_DONE;
         default:  state_n = ST_IDLE;
      endcase
   end

   // Read byte k returns one cycle after its address, i.e. while byte k+1 is issued or in DRAIN.
   always_comb begin
      cnt_n   = cnt_q + 2'd1;
      cap_idx = (state_q == ST_DRAIN) ? len_q : cnt_q - 2'd1;
      asm_n   = asm_q;
      if (!wr_q && (((state_q == ST_XFER) && (cnt_q != 2'd0)) || (state_q == ST_DRAIN)))
         asm_n[{cap_idx, 3'b000} +: 8] = ram_din_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         gnt_q      <= '0;
         wr_q       <= 1'b0;
         len_q      <= '0;
         cnt_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         asm_q      <= '0;
         ch_rdata_o <= '0;
         ch_done_o  <= '0;
         busy_o     <= 1'b0;
         ram_en_o   <= 1'b0;
         ram_wr_o   <= 1'b0;
         ram_addr_o <= '0;
         ram_dout_o <= '0;
      end else begin
         state_q   <= state_n;
         busy_o    <= (state_n != ST_IDLE);
         ram_en_o  <= 1'b0;
         ram_wr_o  <= 1'b0;
         ch_done_o <= '0;
         asm_q     <= asm_n;
         case (state_q)
            ST_IDLE: begin
               if (grant_any) begin
                  gnt_q      <= grant;
                  wr_q       <= sel_wr;
                  len_q      <= sel_len;
                  addr_q     <= sel_addr;
                  wdata_q    <= sel_wdata;
                  cnt_q      <= '0;
                  asm_q      <= '0;
                  ram_en_o   <= 1'b1;
                  ram_wr_o   <= sel_wr;
                  ram_addr_o <= sel_addr;
                  ram_dout_o <= byte_sel(sel_wdata, 2'd0);
               end
            end
            ST_XFER: begin
               if (cnt_q == len_q) begin
                  if (wr_q) ch_done_o <= gnt_q;
               end else begin
                  cnt_q      <= cnt_n;
                  ram_en_o   <= 1'b1;
                  ram_wr_o   <= wr_q;
                  ram_addr_o <= addr_q + ADDR_W'(cnt_n);
                  ram_dout_o <= byte_sel(wdata_q, cnt_n);
               end
            end
            ST_DRAIN: begin
               ch_done_o  <= gnt_q;
               ch_rdata_o <= asm_n;
            end
            default: ;
         endcase
      end
   end

endmodule
